// File: rtl/avalon_burst_mem_slave_pkg.sv
// Shared types and helpers for the Avalon-MM burst memory slave.
package avalon_pkg;

  // Avalon-MM response encoding
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    RSVD   = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  // Slave control states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10,
    RESP  = 2'b11
  } slave_state_e;

  localparam int BUS_ADDR_W = 30;
  localparam int BYTE_W     = 8;

  // Number of word-offset bits covered by the decode window
  function automatic int win_bits(input int mem_words);
    return (mem_words > 1) ? $clog2(mem_words) : 1;
  endfunction

endpackage

// File: rtl/avalon_burst_mem_slave_mem_rd_pipe.sv
// Read-data delay line placed after the registered RAM read.
// With STAGES=0 the RAM output register alone sets the latency.
module mem_rd_pipe
  import avalon_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STAGES = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  resp_e             resp_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output resp_e             resp_o
);

  if (STAGES == 0) begin : g_bypass
    assign valid_o = valid_i;
    assign data_o  = data_i;
    assign resp_o  = resp_i;
  end else begin : g_pipe
    logic [STAGES-1:0] valid_q;
    logic [DATA_W-1:0] data_q [STAGES];
    resp_e             resp_q [STAGES];

    // Shift {valid, data, resp} one stage per cycle; reset drops every pending beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < STAGES; i++) begin
          valid_q[i] <= 1'b0;
          data_q[i]  <= '0;
          resp_q[i]  <= OKAY;
        end
      end else begin
        valid_q[0] <= valid_i;
        data_q[0]  <= data_i;
        resp_q[0]  <= resp_i;
        for (int i = 1; i < STAGES; i++) begin
          valid_q[i] <= valid_q[i-1];
          data_q[i]  <= data_q[i-1];
          resp_q[i]  <= resp_q[i-1];
        end
      end
    end

    assign valid_o = valid_q[STAGES-1];
    assign data_o  = data_q[STAGES-1];
    assign resp_o  = resp_q[STAGES-1];
  end

endmodule

// File: rtl/avalon_burst_mem_slave.sv
// Avalon-MM burst memory slave: single-port RAM behind a decode window,
// per-burst write response and per-beat SLVERR past the populated region.
module avalon_burst_mem_slave
  import avalon_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MEM_WORDS    = 512,
  parameter int          DATA_W       = 32,
  parameter int          BURST_W      = 5,
  parameter int          READ_LATENCY = 1,
  parameter string       LOADFILE     = "none"
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [BURST_W-1:0]    bus_burstcount,
  input  logic [DATA_W-1:0]     bus_writedata,
  input  logic [29:0]           bus_address,
  input  logic                  bus_write,
  input  logic                  bus_read,
  input  logic [DATA_W/8-1:0]   bus_byteenable,
  output logic                  s_waitrequest,
  output logic [DATA_W-1:0]     s_readdata,
  output logic                  s_readdatavalid,
  output logic                  s_writeresponsevalid,
  output logic [1:0]            s_response
);

  localparam int WIN_W = win_bits(MEM_WORDS);
  localparam int BE_W  = DATA_W / BYTE_W;
  localparam int CNT_W = BURST_W + 3;
  localparam logic [WIN_W:0]   MEM_LIMIT = (WIN_W+1)'(MEM_WORDS);
  localparam logic [WIN_W:0]   ADDR_ONE  = (WIN_W+1)'(1);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  slave_state_e        state_q;
  logic                wait_q, wrv_q, werr_q;
  resp_e               wresp_q;
  logic [WIN_W:0]      addr_q;
  logic [BURST_W-1:0]  issue_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BE_W-1:0]     be_q;

  logic [DATA_W-1:0]   mem_q [MEM_WORDS];
  logic [DATA_W-1:0]   ram_rdata_q;
  logic                rd_valid_q, rd_err_q;

  logic [BUS_ADDR_W-1:0] addr_xor;
  logic                  sel;
  logic [WIN_W:0]        cmd_off, mem_addr;
  logic [WIN_W-1:0]      mem_idx;
  logic [BURST_W-1:0]    burst_eff;
  logic                  accept_rd, accept_wr, wbeat, rd_issue, mem_oor, wr_en;
  logic [BE_W-1:0]       wr_be;
  logic [DATA_W-1:0]     be_mask, stage_data;
  resp_e                 stage_resp, pipe_resp;
  logic                  pipe_valid;
  logic [DATA_W-1:0]     pipe_data;

  assign addr_xor  = bus_address ^ BASE_ADDR[31:2];
  assign sel       = (addr_xor >> WIN_W) == '0;
  assign cmd_off   = {1'b0, bus_address[WIN_W-1:0]};
  assign burst_eff = (bus_burstcount == '0) ? BURST_ONE : bus_burstcount;
  assign mem_idx   = mem_addr[WIN_W-1:0];

  // Command acceptance and the shared RAM port: commands use the bus address,
  // later beats of a burst use the running counter
  always_comb begin
    accept_rd = (state_q == IDLE) && !wait_q && sel && bus_read;
    accept_wr = (state_q == IDLE) && !wait_q && sel && bus_write && !bus_read;
    wbeat     = (state_q == WRITE) && bus_write;
    rd_issue  = accept_rd || ((state_q == READ) && (issue_q != '0));
    mem_addr  = (accept_rd || accept_wr) ? cmd_off : addr_q;
    mem_oor   = mem_addr >= MEM_LIMIT;
    wr_en     = (accept_wr || wbeat) && !mem_oor;
    wr_be     = accept_wr ? bus_byteenable : be_q;
  end

  // Byte-lane merge write; disabled lanes keep their old contents
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) mem_q[mem_idx][BYTE_W*b +: BYTE_W] <= bus_writedata[BYTE_W*b +: BYTE_W];
      end
    end
  end

  // Registered RAM read; out-of-range beats never touch the array
  always_ff @(posedge clk_i) begin
    if (rd_issue && !mem_oor) ram_rdata_q <= mem_q[mem_idx];
  end

  // Qualifiers travelling alongside the RAM output register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_issue;
      rd_err_q   <= mem_oor;
    end
  end

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_be_mask
    assign be_mask[BYTE_W*gi +: BYTE_W] = {BYTE_W{be_q[gi]}};
  end

  assign stage_data = (rd_valid_q && !rd_err_q) ? (ram_rdata_q & be_mask) : '0;
  assign stage_resp = (rd_valid_q && rd_err_q) ? SLVERR : OKAY;

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (READ_LATENCY - 1)
  ) u_rd_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (rd_valid_q),
    .data_i  (stage_data),
    .resp_i  (stage_resp),
    .valid_o (pipe_valid),
    .data_o  (pipe_data),
    .resp_o  (pipe_resp)
  );

  // Control FSM with registered waitrequest and write-response outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wait_q  <= 1'b1;
      wrv_q   <= 1'b0;
      wresp_q <= OKAY;
      werr_q  <= 1'b0;
      addr_q  <= '0;
      issue_q <= '0;
      cnt_q   <= '0;
      be_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wait_q <= 1'b0;
          if (accept_rd) begin
            state_q <= READ;
            wait_q  <= 1'b1;
            addr_q  <= cmd_off + ADDR_ONE;
            issue_q <= burst_eff - BURST_ONE;
            // READ lasts until the last beat has left the pipeline
            cnt_q   <= CNT_W'(burst_eff) + CNT_W'(READ_LATENCY - 1);
            be_q    <= bus_byteenable;
          end else if (accept_wr) begin
            be_q   <= bus_byteenable;
            addr_q <= cmd_off + ADDR_ONE;
            werr_q <= mem_oor;
            if (burst_eff > BURST_ONE) begin
              state_q <= WRITE;
              issue_q <= burst_eff - BURST_ONE;
            end else begin
              state_q <= RESP;
              wait_q  <= 1'b1;
              wrv_q   <= 1'b1;
              wresp_q <= mem_oor ? SLVERR : OKAY;
            end
          end
        end
        WRITE: begin
          if (bus_write) begin
            addr_q  <= addr_q + ADDR_ONE;
            issue_q <= issue_q - BURST_ONE;
            werr_q  <= werr_q | mem_oor;
            if (issue_q == BURST_ONE) begin
              state_q <= RESP;
              wait_q  <= 1'b1;
              wrv_q   <= 1'b1;
              wresp_q <= (werr_q | mem_oor) ? SLVERR : OKAY;
            end
          end
        end
        READ: begin
          if (issue_q != '0) begin
            addr_q  <= addr_q + ADDR_ONE;
            issue_q <= issue_q - BURST_ONE;
          end
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            wait_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          wait_q  <= 1'b0;
          wrv_q   <= 1'b0;
          wresp_q <= OKAY;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_waitrequest        = wait_q;
  assign s_writeresponsevalid = wrv_q;
  assign s_readdatavalid      = pipe_valid;
  assign s_readdata           = pipe_data;
  assign s_response           = pipe_valid ? pipe_resp : (wrv_q ? wresp_q : OKAY);

endmodule

// File: tb/tb_avalon_burst_mem_slave.sv
// Directed bench for avalon_burst_mem_slave with a read/write-response scoreboard.
module tb_avalon_burst_mem_slave;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WBASE = 32'h400;
  localparam int          MW    = 500;
  localparam int          RL    = 3;

  logic        clk, rst_ni;
  logic [4:0]  bus_burstcount;
  logic [31:0] bus_writedata;
  logic [29:0] bus_address;
  logic        bus_write, bus_read;
  logic [3:0]  bus_byteenable;
  logic        s_waitrequest, s_readdatavalid, s_writeresponsevalid;
  logic [31:0] s_readdata;
  logic [1:0]  s_response;

  avalon_burst_mem_slave #(
    .BASE_ADDR(BASE), .MEM_WORDS(MW), .DATA_W(32), .BURST_W(5),
    .READ_LATENCY(RL), .LOADFILE("none")
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus_burstcount(bus_burstcount),
    .bus_writedata(bus_writedata), .bus_address(bus_address),
    .bus_write(bus_write), .bus_read(bus_read), .bus_byteenable(bus_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .s_writeresponsevalid(s_writeresponsevalid),
    .s_response(s_response)
  );

  typedef struct packed { logic [31:0] data; logic [1:0] resp; int cyc; } rd_exp_t;
  typedef struct packed { logic [1:0] resp; int cyc; } wr_exp_t;

  rd_exp_t     rq[$];
  wr_exp_t     wq[$];
  logic [31:0] model [512];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  rd_exp_t     rd_e;
  wr_exp_t     wr_e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 64 && s_waitrequest; i++) step();
    check("ready", 64'(s_waitrequest), 64'd0);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // Scoreboard consumer: one read beat or write response per line
  always @(negedge clk) begin
    if (rst_ni) begin
      if (s_readdatavalid) begin
        if (rq.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
        else begin
          rd_e = rq.pop_front();
          $display("read beat  cyc=%0d data=%08h resp=%0b", cyc, s_readdata, s_response);
          check("rd_data", 64'(s_readdata), 64'(rd_e.data));
          check("rd_resp", 64'(s_response), 64'(rd_e.resp));
          check("rd_cycle", 64'(cyc), 64'(rd_e.cyc));
        end
      end
      if (s_writeresponsevalid) begin
        if (wq.size() == 0) check("wresp_unexpected", 64'd1, 64'd0);
        else begin
          wr_e = wq.pop_front();
          $display("write resp cyc=%0d resp=%0b", cyc, s_response);
          check("wresp", 64'(s_response), 64'(wr_e.resp));
          check("wresp_cycle", 64'(cyc), 64'(wr_e.cyc));
        end
      end
    end
  end

  task automatic do_write(input int off, input int n, input logic [3:0] be,
                          input logic [31:0] d0, input int stall_at, input int stall_n);
    logic        err;
    int          t;
    logic [31:0] d, m;
    err = 1'b0;
    t   = 0;
    m   = lane_mask(be);
    wait_ready();
    for (int i = 0; i < n; i++) begin
      d = d0 + 32'(i) * 32'h0101_0101;
      bus_write = 1'b1; bus_read = 1'b0;
      bus_address = 30'(WBASE + off); bus_burstcount = 5'(n);
      bus_byteenable = be; bus_writedata = d;
      if (i > 0) check("wr_beat_wait", 64'(s_waitrequest), 64'd0);
      t = cyc;
      if (off + i < MW) model[off+i] = (model[off+i] & ~m) | (d & m);
      else err = 1'b1;
      step();
      if (i == stall_at) begin
        bus_write = 1'b0;
        repeat (stall_n) step();
      end
    end
    bus_write = 1'b0;
    wq.push_back('{resp: (err ? 2'b10 : 2'b00), cyc: t + 1});
    check("resp_wait", 64'(s_waitrequest), 64'd1);
  endtask

  task automatic push_reads(input int off, input int n, input logic [3:0] be, input int t);
    for (int k = 0; k < n; k++) begin
      if (off + k < MW) rq.push_back('{data: model[off+k] & lane_mask(be), resp: 2'b00, cyc: t + RL + k});
      else              rq.push_back('{data: 32'h0, resp: 2'b10, cyc: t + RL + k});
    end
  endtask

  task automatic do_read(input int off, input int n_bc, input logic [3:0] be, input logic wr_too);
    int n, t;
    n = (n_bc == 0) ? 1 : n_bc;
    wait_ready();
    bus_read = 1'b1; bus_write = wr_too; bus_writedata = 32'h1234_5678;
    bus_byteenable = be; bus_address = 30'(WBASE + off); bus_burstcount = 5'(n_bc);
    t = cyc;
    push_reads(off, n, be, t);
    step();
    bus_read = 1'b0; bus_write = 1'b0;
    for (int c = 1; c <= RL + n; c++) begin
      check("rd_wait", 64'(s_waitrequest), 64'(c < RL + n));
      if (c < RL + n) step();
    end
  endtask

  initial begin
    int t;
    rst_ni = 1'b0; bus_write = 1'b0; bus_read = 1'b0; bus_address = '0;
    bus_burstcount = '0; bus_writedata = '0; bus_byteenable = '0;
    repeat (3) step();
    check("rst_wait", 64'(s_waitrequest), 64'd1);
    check("rst_rdv", 64'(s_readdatavalid), 64'd0);
    check("rst_rdata", 64'(s_readdata), 64'd0);
    check("rst_wrv", 64'(s_writeresponsevalid), 64'd0);
    check("rst_resp", 64'(s_response), 64'd0);
    rst_ni = 1'b1;
    check("rel_wait_hold", 64'(s_waitrequest), 64'd1);
    step();
    check("idle_wait", 64'(s_waitrequest), 64'd0);

    // Partial-lane write over an all-ones word
    do_write(0, 1, 4'hF, 32'hFFFF_FFFF, -1, 0);
    step();
    check("next_cmd_t2", 64'(s_waitrequest), 64'd0);
    do_write(0, 1, 4'b0011, 32'hCAFE_BABE, -1, 0);
    check("model_merge", 64'(model[0]), 64'hFFFF_BABE);
    do_read(0, 1, 4'hF, 1'b0);

    // Burst write of 8 then burst read of 4 from byte offset 8
    do_write(2, 8, 4'hF, 32'h1122_3344, -1, 0);
    do_read(2, 4, 4'hF, 1'b0);

    // Stalled burst write of 3; neighbour word must be untouched
    do_write(13, 1, 4'hF, 32'hDEAD_0013, -1, 0);
    do_write(10, 3, 4'hF, 32'hA0A0_A000, 1, 2);
    do_read(10, 4, 4'hF, 1'b0);

    // Bursts crossing the populated limit
    do_write(498, 2, 4'hF, 32'h4980_0000, -1, 0);
    do_write(499, 2, 4'hF, 32'h5990_0000, -1, 0);
    do_read(498, 4, 4'hF, 1'b0);
    do_write(505, 1, 4'hF, 32'h0505_0505, -1, 0);

    // Outside the decode window: no stall, no activity
    wait_ready();
    bus_write = 1'b1; bus_address = 30'(WBASE + 512); bus_burstcount = 5'd1;
    bus_writedata = 32'h5555_5555; bus_byteenable = 4'hF;
    repeat (3) begin
      step();
      check("oow_wr_wait", 64'(s_waitrequest), 64'd0);
      check("oow_resp", 64'(s_response), 64'd0);
    end
    bus_write = 1'b0; bus_read = 1'b1; bus_address = 30'(WBASE - 1);
    repeat (3) begin
      step();
      check("oow_rd_wait", 64'(s_waitrequest), 64'd0);
      check("oow_rdv", 64'(s_readdatavalid), 64'd0);
    end
    bus_read = 1'b0;
    do_read(0, 1, 4'hF, 1'b0);

    // Read and write together: read wins, memory untouched
    do_read(0, 1, 4'hF, 1'b1);
    do_read(0, 1, 4'hF, 1'b0);

    // Burstcount 0 acts as 1; upper lanes only
    do_read(3, 0, 4'b1100, 1'b0);

    // Reset in the middle of a read burst of 8
    wait_ready();
    bus_read = 1'b1; bus_address = 30'(WBASE + 2); bus_burstcount = 5'd8; bus_byteenable = 4'hF;
    t = cyc;
    push_reads(2, 8, 4'hF, t);
    step();
    bus_read = 1'b0;
    repeat (4) step();
    check("rdv_before_rst", 64'(s_readdatavalid), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_async_rdv", 64'(s_readdatavalid), 64'd0);
    check("rst_async_rdata", 64'(s_readdata), 64'd0);
    check("rst_async_wait", 64'(s_waitrequest), 64'd1);
    rq.delete();
    repeat (2) step();
    rst_ni = 1'b1;
    step();
    check("post_rst_wait", 64'(s_waitrequest), 64'd0);
    do_read(0, 1, 4'hF, 1'b0);
    do_read(2, 8, 4'hF, 1'b0);

    repeat (10) step();
    check("rd_queue_empty", 64'(rq.size()), 64'd0);
    check("wr_queue_empty", 64'(wq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
